irq_service_master: RTL
=======================

Name: irq_service_master

Overview:
- APB requester that services the interrupt handler from the CPU side. It is the initiator counterpart of the handler's APB register slave.
- On an asserted interrupt line it reads status registers ISRA (0x0B) and ISRB (0x0C), selects the highest-priority pending source and presents its vector ID to the core.
- After the core acknowledges the vector, it clears that status bit with a write-1-to-clear APB write, then returns to idle.

Parameters:
- ISRA_ADDR, 8'h0B, APB address of status register A (sources 0-7)
- ISRB_ADDR, 8'h0C, APB address of status register B (sources 8-15)
- TIMEOUT, 16, max access-phase cycles waiting for pready before abort (legal range 1..255)

Ports:
- pclk  in  1  clock
- preset  in  1  synchronous reset, active-high
- intr  in  1  level interrupt request from handler
- nmi  in  1  level NMI request from handler
- paddr  out  8  APB address
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB write strobe
- pwdata  out  8  APB write data
- prdata  in  8  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB slave error
- vec_valid  out  1  vector available to core
- vec_id  out  5  vector: 0-15 = status bit index, 16 = NMI, 31 = spurious
- vec_ready  in  1  core accepts vector
- busy  out  1  high whenever FSM is not IDLE
- err  out  1  sticky error (pslverr or timeout); cleared only by reset

Behaviour:
- Reset (sampled on pclk rising edge while preset=1): FSM=IDLE. All outputs 0: paddr, pwdata, psel, penable, pwrite, vec_valid, vec_id, busy, err. Captured status cleared. Reset mid-transfer abandons the APB transfer immediately; psel drops on the next edge.
- APB rules:
  - SETUP phase: one cycle, psel=1, penable=0.
  - ACCESS phase: psel=1, penable=1, held until pready=1.
  - paddr, pwrite and pwdata stay stable from SETUP through completion.
  - prdata is captured only on the cycle with pready=1, penable=1 and pwrite=0.
  - Back-to-back transfers go through at least one cycle with psel=0.
- FSM states: IDLE, RDA_S, RDA_A, RDB_S, RDB_A, PRESENT, CLR_S, CLR_A.
- IDLE:
  - nmi=1 takes priority: go to PRESENT with vec_id=16.
  - Otherwise intr=1: go to RDA_S.
  - Both sampled on the same edge: NMI wins; intr stays pending and is serviced afterwards.
- RDA_S/RDA_A: read ISRA_ADDR; on completion store stat[7:0] and go to RDB_S.
- RDB_S/RDB_A: read ISRB_ADDR; on completion store stat[15:8] and go to PRESENT.
- Priority: lowest set index of stat[15:0] wins. stat=0 gives vec_id=31 (spurious).
- PRESENT:
  - vec_valid=1 with vec_id stable until the cycle with vec_ready=1.
  - vec_valid deasserts on the following edge.
  - vec_id 16 or 31: return to IDLE; no clear write is issued.
  - Otherwise go to CLR_S.
- CLR_S/CLR_A:
  - pwrite=1, pwdata = 1<<(id%8).
  - paddr = ISRA_ADDR for id<8, else ISRB_ADDR.
  - On completion go to IDLE.
- Latency: intr rise to vec_valid is 5 cycles with zero-wait-state slave (2 cycles per read plus 1 to PRESENT).
- Timeout: an ACCESS-phase counter counts cycles with pready=0. Reaching TIMEOUT sets err, drops psel/penable on the next edge and returns to IDLE.
- pslverr=1 with pready=1: set err and return to IDLE; no vector is presented and no clear is issued.
- vec_ready while not in PRESENT is ignored.
- intr or nmi toggling outside IDLE is ignored; the level is re-sampled in IDLE.

Test Plan:
- Reset, zero-wait slave, ISRA=8'h00, ISRB=8'h30, pulse intr:
  - reads 0x0B then 0x0C; vec_valid on cycle 5 with vec_id=12.
  - after vec_ready, write paddr=0x0C, pwdata=8'h10.
- ISRA=8'hFF, ISRB=8'hFF: vec_id=0 → clear write 0x0B/8'h01.
- Repeat until status is empty: ids 1..7 then 8..15, each cleared in order; final intr drop → busy=0.
- nmi and intr asserted together: vec_id=16 first with no APB write; then ISR reads proceed.
- ISRA=ISRB=0 with intr=1: vec_id=31 with no clear write; slave inserts 3 wait states, so latency is 11 cycles and psel/penable/paddr stay stable during the waits.
- Error and reset cases:
  - pready held 0 for 16 cycles: err=1, psel=0, back to IDLE.
  - pslverr on RDB: err=1, vec_valid never asserts.
  - preset during CLR_A: all outputs 0 on the next edge.

Source files
------------

// File: rtl/irq_service_master.sv
`default_nettype none
// ============================================================================
// Module      : irq_service_master
// Description : APB requester that reads the interrupt handler's ISRA/ISRB
//               status, presents the highest-priority vector to the core and
//               clears the serviced bit with a write-1-to-clear transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_service_master #(
  parameter logic [7:0]  ISRA_ADDR = 8'h0B,
  parameter logic [7:0]  ISRB_ADDR = 8'h0C,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       intr,
  input  logic       nmi,
  output logic [7:0] paddr,
  output logic       psel,
  output logic       penable,
  output logic       pwrite,
  output logic [7:0] pwdata,
  input  logic [7:0] prdata,
  input  logic       pready,
  input  logic       pslverr,
  output logic       vec_valid,
  output logic [4:0] vec_id,
  input  logic       vec_ready,
  output logic       busy,
  output logic       err
);

  localparam logic [4:0] C_VEC_NMI      = 5'd16;
  localparam logic [4:0] C_VEC_SPURIOUS = 5'd31;
  localparam logic [7:0] C_TMO_LAST     = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RDA_S   = 3'd1,
    S_RDA_A   = 3'd2,
    S_RDB_S   = 3'd3,
    S_RDB_A   = 3'd4,
    S_PRESENT = 3'd5,
    S_CLR_S   = 3'd6,
    S_CLR_A   = 3'd7
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_vec_id;
  logic [4:0]  w_vec_id_nxt;
  logic [7:0]  r_stat_a;
  logic [7:0]  r_wait_cnt;
  logic        r_err;

  logic        w_access;
  logic        w_done;
  logic        w_fail;
  logic        w_timeout;
  logic [15:0] w_stat;
  logic [4:0]  w_prio;
  logic [7:0]  w_clr_addr;

  assign w_access  = (r_state == S_RDA_A) || (r_state == S_RDB_A) ||
                     (r_state == S_CLR_A);
  assign w_done    = w_access && pready;
  assign w_fail    = w_done && pslverr;
  assign w_timeout = w_access && !pready && (r_wait_cnt == C_TMO_LAST);

  // ISRB arrives on the same cycle the decision is made, so it is taken
  // straight from the bus rather than from a register.
  assign w_stat = {prdata, r_stat_a};

  always_comb begin
    w_prio = C_VEC_SPURIOUS;
    for (int i = 15; i >= 0; i--) begin
      if (w_stat[i]) begin
        w_prio = 5'(i);
      end
    end
  end

  assign w_clr_addr = r_vec_id[3] ? ISRB_ADDR : ISRA_ADDR;

  always_ff @(posedge pclk) begin
    if (preset) begin
      r_state    <= S_IDLE;
      r_vec_id   <= 5'd0;
      r_stat_a   <= 8'd0;
      r_wait_cnt <= 8'd0;
      r_err      <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_vec_id <= w_vec_id_nxt;
      if ((r_state == S_RDA_A) && w_done) begin
        r_stat_a <= prdata;
      end
      if (w_access && !pready) begin
        r_wait_cnt <= r_wait_cnt + 8'd1;
      end else begin
        r_wait_cnt <= 8'd0;
      end
      if (w_fail || w_timeout) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_vec_id_nxt = r_vec_id;
    case (r_state)
      S_IDLE: begin
        if (nmi) begin
          w_state_nxt  = S_PRESENT;
          w_vec_id_nxt = C_VEC_NMI;
        end else if (intr) begin
          w_state_nxt = S_RDA_S;
        end
      end
      S_RDA_S: w_state_nxt = S_RDA_A;
      S_RDA_A: begin
        if (w_fail || w_timeout) begin
          w_state_nxt = S_IDLE;
        end else if (w_done) begin
          w_state_nxt = S_RDB_S;
        end
      end
      S_RDB_S: w_state_nxt = S_RDB_A;
      S_RDB_A: begin
        if (w_fail || w_timeout) begin
          w_state_nxt = S_IDLE;
        end else if (w_done) begin
          w_state_nxt  = S_PRESENT;
          w_vec_id_nxt = w_prio;
        end
      end
      S_PRESENT: begin
        if (vec_ready) begin
          // NMI and spurious vectors have no status bit to clear.
          w_state_nxt = r_vec_id[4] ? S_IDLE : S_CLR_S;
        end
      end
      S_CLR_S: w_state_nxt = S_CLR_A;
      S_CLR_A: begin
        if (w_done || w_timeout) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    paddr     = 8'd0;
    psel      = 1'b0;
    penable   = 1'b0;
    pwrite    = 1'b0;
    pwdata    = 8'd0;
    vec_valid = 1'b0;
    case (r_state)
      S_RDA_S, S_RDA_A: begin
        paddr   = ISRA_ADDR;
        psel    = 1'b1;
        penable = (r_state == S_RDA_A);
      end
      S_RDB_S, S_RDB_A: begin
        paddr   = ISRB_ADDR;
        psel    = 1'b1;
        penable = (r_state == S_RDB_A);
      end
      S_CLR_S, S_CLR_A: begin
        paddr   = w_clr_addr;
        psel    = 1'b1;
        penable = (r_state == S_CLR_A);
        pwrite  = 1'b1;
        pwdata  = 8'd1 << r_vec_id[2:0];
      end
      S_PRESENT: vec_valid = 1'b1;
      default: ;
    endcase
  end

  assign vec_id = r_vec_id;
  assign busy   = (r_state != S_IDLE);
  assign err    = r_err;

endmodule
`default_nettype wire
